// File: rtl/ifetch_ctrl_pkg.sv
// Shared core package: fetch FSM state encoding and the default fault filler word.
package ifetch_ctrl_pkg;

    // state | meaning
    // IDLE  | first cycle after reset, nothing outstanding
    // REQ   | presenting pc_cur to instruction memory
    // WAIT  | one request accepted, response pending
    // HOLD  | instruction (or fault) buffered and offered to decode
    // DROP  | redirected while waiting; next response is stale
    // FLT   | fault consumed, parked until a redirect arrives
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4,
        FLT  = 3'd5
    } ifetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, single-entry
// output buffer towards decode, redirect handling with stale-response drop,
// and an optional misaligned-PC fault path.
//
// state | meaning
// IDLE  | first cycle after reset, nothing outstanding
// REQ   | presenting pc_cur to instruction memory
// WAIT  | one request accepted, response pending
// HOLD  | instruction (or fault) buffered; if_valid high
// DROP  | redirected while waiting; next response is discarded
// FLT   | fault consumed, no fetching until a redirect
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter bit          CHECK_ALIGN = 1'b1,
    parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_cur,
    output logic        pc_en,
    output logic        pc_load,
    output logic [31:0] pc_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_fault
);

    ifetch_state_t state, state_nxt;
    logic [31:0]   req_pc;
    logic          misaligned;
    logic          accept;
    logic          take_rsp;
    logic          take_fault;

    assign misaligned    = CHECK_ALIGN && (pc_cur[1:0] != 2'b00);
    assign imem_req_addr = pc_cur;
    assign pc_in         = redirect_pc;
    assign if_valid      = (state == HOLD);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode plus memory request and PC register controls.
    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        pc_en          = 1'b0;
        pc_load        = 1'b0;
        accept         = 1'b0;
        take_rsp       = 1'b0;
        take_fault     = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (redirect_valid) begin
                    state_nxt = REQ;
                end else if (misaligned) begin
                    take_fault = 1'b1;
                    state_nxt  = HOLD;
                end else begin
                    imem_req_valid = 1'b1;
                    if (imem_req_ready) begin
                        accept    = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_nxt = imem_rsp_valid ? REQ : DROP;
                end else if (imem_rsp_valid) begin
                    take_rsp  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // A redirect kills the buffered instruction even if decode is ready.
                if (redirect_valid)  state_nxt = REQ;
                else if (if_ready)   state_nxt = if_fault ? FLT : REQ;
            end
            DROP: begin
                if (imem_rsp_valid) state_nxt = REQ;
            end
            FLT: begin
                if (redirect_valid) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
        if (redirect_valid) begin
            pc_load = 1'b1;
            pc_en   = 1'b1;
        end
        if (accept) pc_en = 1'b1;
        // Reset is synchronous, but the PC and memory controls must stay quiet
        // for the whole time rst_n is low, not just after the next edge.
        if (!rst_n) begin
            imem_req_valid = 1'b0;
            pc_en          = 1'b0;
            pc_load        = 1'b0;
        end
    end

    // Request PC capture and the output buffer towards decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_pc   <= '0;
            if_instr <= '0;
            if_pc    <= '0;
            if_fault <= 1'b0;
        end else begin
            if (accept) req_pc <= pc_cur;
            if (take_rsp) begin
                if_instr <= imem_rsp_data;
                if_pc    <= req_pc;
                if_fault <= 1'b0;
            end else if (take_fault) begin
                if_instr <= NOP_INSTR;
                if_pc    <= pc_cur;
                if_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl; the bench plays the PC register and memory.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_cur;
    logic        pc_en, pc_load;
    logic [31:0] pc_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic        if_fault;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_cur         (pc_cur),
        .pc_en          (pc_en),
        .pc_load        (pc_load),
        .pc_in          (pc_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_fault       (if_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let inputs be driven 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        pc_cur         = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if_ready       = 1'b0;
        tick();
        tick();
        settle();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_pc_en",     pc_en, 0);
        chk("rst_if_valid",  if_valid, 0);
        chk("rst_if_fault",  if_fault, 0);
        chk("rst_if_instr",  if_instr, 0);
        chk("rst_if_pc",     if_pc, 0);

        // Release; IDLE issues nothing, then REQ with memory stalled 3 cycles.
        rst_n = 1'b1;
        settle();
        chk("idle_no_req", imem_req_valid, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_valid", imem_req_valid, 1);
            chk("stall_addr",  imem_req_addr, 32'h0);
            chk("stall_pc_en", pc_en, 0);
            tick();
        end
        imem_req_ready = 1'b1;
        settle();
        chk("acc_pc_en", pc_en, 1);
        chk("acc_pc_load", pc_load, 0);
        tick();
        imem_req_ready = 1'b0;
        pc_cur = 32'h4;
        settle();
        chk("wait_pc_en",  pc_en, 0);
        chk("wait_no_req", imem_req_valid, 0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0050_0093;
        tick();
        imem_rsp_valid = 1'b0;
        settle();
        chk("hold_valid", if_valid, 1);
        chk("hold_pc",    if_pc, 32'h0);
        chk("hold_instr", if_instr, 32'h0050_0093);
        chk("hold_fault", if_fault, 0);
        chk("hold_no_req", imem_req_valid, 0);
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        settle();
        chk("after_cons_valid", if_valid, 0);
        chk("req2_addr", imem_req_addr, 32'h4);

        // Redirect during WAIT, stale response discarded in DROP.
        imem_req_ready = 1'b1;
        settle();
        chk("req2_valid", imem_req_valid, 1);
        tick();
        imem_req_ready = 1'b0;
        pc_cur = 32'h8;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        settle();
        chk("redir_load", pc_load, 1);
        chk("redir_en",   pc_en, 1);
        chk("redir_pc_in", pc_in, 32'h100);
        tick();
        redirect_valid = 1'b0;
        pc_cur = 32'h100;
        settle();
        chk("drop_no_req", imem_req_valid, 0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        settle();
        chk("stale_no_valid", if_valid, 0);
        chk("newreq_valid", imem_req_valid, 1);
        chk("newreq_addr",  imem_req_addr, 32'h100);

        // Fetch 0x100, then hold with decode stalled 4 cycles, then kill.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        pc_cur = 32'h104;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00A0_0113;
        tick();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("stall_hold_valid", if_valid, 1);
            chk("stall_hold_instr", if_instr, 32'h00A0_0113);
            chk("stall_hold_pc",    if_pc, 32'h100);
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h180;
        if_ready       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        // Misaligned PC presented in REQ.
        pc_cur = 32'h102;
        settle();
        chk("kill_valid", if_valid, 0);
        chk("mis_no_req", imem_req_valid, 0);
        chk("mis_no_pc_en", pc_en, 0);
        tick();
        settle();
        chk("flt_valid", if_valid, 1);
        chk("flt_fault", if_fault, 1);
        chk("flt_instr", if_instr, 32'h0000_0013);
        chk("flt_pc",    if_pc, 32'h102);
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("park_valid",  if_valid, 0);
            chk("park_no_req", imem_req_valid, 0);
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        settle();
        chk("park_redir_load", pc_load, 1);
        tick();
        redirect_valid = 1'b0;
        pc_cur = 32'h200;
        settle();
        chk("resume_valid", imem_req_valid, 1);
        chk("resume_addr",  imem_req_addr, 32'h200);

        // Redirect and response in the same WAIT cycle: response dropped.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        pc_cur = 32'h204;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_2222;
        tick();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        pc_cur = 32'h300;
        settle();
        chk("same_cyc_no_valid", if_valid, 0);
        chk("same_cyc_req",      imem_req_valid, 1);
        chk("same_cyc_addr",     imem_req_addr, 32'h300);

        // Fetch a word into the buffer, then reset from WAIT.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        pc_cur = 32'h304;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h3333_4444;
        tick();
        imem_rsp_valid = 1'b0;
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        pc_cur = 32'h308;
        rst_n = 1'b0;
        settle();
        chk("rstw_pc_en", pc_en, 0);
        tick();
        settle();
        chk("rstw_req_valid", imem_req_valid, 0);
        chk("rstw_if_valid",  if_valid, 0);
        chk("rstw_if_instr",  if_instr, 0);
        chk("rstw_if_pc",     if_pc, 0);
        chk("rstw_if_fault",  if_fault, 0);
        rst_n = 1'b1;
        settle();
        chk("rstw_idle", imem_req_valid, 0);
        tick();
        settle();
        chk("rstw_req_valid2", imem_req_valid, 1);
        chk("rstw_req_addr",   imem_req_addr, 32'h308);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter: CHECK_ALIGN, 1, when 1 a PC with pc[1:0]!=0 raises fault instead of issuing a request.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, instruction word presented with a fault.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 pc_cur  in  32  current PC from the PC register.
REQ-006 pc_en  out  1  PC register advance enable.
REQ-007 pc_load  out  1  PC register load select.
REQ-008 pc_in  out  32  PC register load value.
REQ-009 redirect_valid  in  1  branch/trap redirect, single-cycle pulse.
REQ-010 redirect_pc  in  32  redirect target.
REQ-011 imem_req_valid  out  1  instruction memory request valid.
REQ-012 imem_req_ready  in  1  memory accepts request.
REQ-013 imem_req_addr  out  32  request address.
REQ-014 imem_rsp_valid  in  1  response valid, exactly one per accepted request, at least 1 cycle after acceptance.
REQ-015 imem_rsp_data  in  32  instruction word.
REQ-016 if_valid  out  1  fetched instruction valid to decode.
REQ-017 if_ready  in  1  decode accepts.
REQ-018 if_instr  out  32  instruction word.
REQ-019 if_pc  out  32  PC of if_instr.
REQ-020 if_fault  out  1  misaligned-fetch fault flag for if_instr.

Function
REQ-021 FSM states SHALL be: IDLE, REQ, WAIT, HOLD, DROP, FLT; at most one memory request outstanding.
REQ-022 IDLE SHALL go to REQ on the next cycle unconditionally.
REQ-023 imem_req_valid SHALL = (state==REQ) && !redirect_valid && !misaligned; imem_req_addr = pc_cur.
REQ-024 On acceptance (valid&&ready): capture pc_cur into req_pc, assert pc_en in the same cycle, go to WAIT.
REQ-025 pc_load SHALL equal redirect_valid; pc_in SHALL equal redirect_pc; pc_en SHALL be asserted on acceptance OR redirect_valid.
REQ-026 WAIT + imem_rsp_valid: latch imem_rsp_data and req_pc into output buffer, if_fault=0, go to HOLD.
REQ-027 HOLD: if_valid=1, outputs stable; if_valid&&if_ready goes to REQ (no same-cycle re-request; minimum 3 cycles per instruction with 1-cycle memory).
REQ-028 REQ with CHECK_ALIGN=1 and pc_cur[1:0]!=0 and no redirect: no request, no pc_en; buffer if_instr=NOP_INSTR, if_pc=pc_cur, if_fault=1, go to HOLD.
REQ-029 Fault consumed in HOLD SHALL go to FLT; FLT holds, no requests, until redirect_valid, then goes to REQ.
REQ-030 redirect_valid in REQ or IDLE: go to REQ (new PC used next cycle).
REQ-031 redirect_valid in WAIT without rsp: go to DROP; with rsp in the same cycle: discard rsp, go to REQ.
REQ-032 redirect_valid in HOLD: clear if_valid, go to REQ, even if if_ready is high the same cycle (instruction killed).
REQ-033 DROP: discard the next imem_rsp_valid and go to REQ; redirect in DROP stays in DROP (or goes to REQ if rsp arrives in the same cycle).
REQ-034 if_valid SHALL be 1 only in HOLD; decode never observes a killed instruction.

Reset
REQ-035 While rst_n=0: state=IDLE, imem_req_valid=0, pc_en=0, pc_load=0, if_valid=0, if_fault=0, if_instr=0, if_pc=0, req_pc=0.
REQ-036 Instruction memory shares rst_n; no pre-reset response SHALL arrive after reset, so reset mid-WAIT needs no drop tracking.

Structure
REQ-037 FSM state enum and NOP_INSTR default SHALL live in the shared core package.
REQ-038 Single flat module; no sub-modules.

Verification
REQ-039 pc_cur=0x0, ready=1, rsp 1 cycle later with 0x00500093, if_ready=1 -> if_valid with if_pc=0x0, if_instr=0x00500093; one pc_en pulse.
REQ-040 ready=0 for 3 cycles -> imem_req_valid and addr 0x0 held stable, pc_en=0 until acceptance.
REQ-041 Redirect to 0x100 in WAIT, rsp next cycle -> rsp discarded, next request addr=0x100, no if_valid for stale word.
REQ-042 HOLD with if_ready=0 for 4 cycles -> if_instr/if_pc stable; redirect during HOLD -> if_valid drops, no handshake.
REQ-043 pc_cur=0x102 -> no memory request, if_fault=1, if_instr=0x00000013; after consume, idle in FLT until redirect to 0x200, then request 0x200.
REQ-044 rst_n low during WAIT -> all outputs zero next edge; after release, IDLE then request at pc_cur.
